// File: rtl/sequence_generator.sv
// Frame sequence generator: drives the 8-symbol frame onto a valid/ready
// symbol bus, repeated a latched number of times with a latched idle gap.
module sequence_generator #(
  parameter logic [2:0]  IDLE_DATA = 3'b111,
  parameter int unsigned REP_W     = 8,
  parameter int unsigned GAP_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REP_W-1:0] repeat_count,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic             abort,
  input  logic             ready,
  output logic [2:0]       data,
  output logic             data_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W    = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(7);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [REP_W-1:0] reps;
  logic [GAP_W-1:0] gap_len;
  logic [GAP_W-1:0] gap_cnt;

  function automatic logic [2:0] frame_sym(input logic [IDX_W-1:0] i);
    case (i)
      3'd0:    frame_sym = 3'b001;
      3'd1:    frame_sym = 3'b101;
      3'd2:    frame_sym = 3'b110;
      3'd3:    frame_sym = 3'b000;
      3'd4:    frame_sym = 3'b110;
      3'd5:    frame_sym = 3'b110;
      3'd6:    frame_sym = 3'b011;
      default: frame_sym = 3'b101;
    endcase
  endfunction

  // Outputs are updated together with the state so every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      reps       <= '0;
      gap_len    <= '0;
      gap_cnt    <= '0;
      data       <= IDLE_DATA;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            reps       <= (repeat_count == '0) ? REP_W'(1) : repeat_count;
            gap_len    <= gap_cycles;
            idx        <= '0;
            state      <= SEND;
            data       <= frame_sym('0);
            data_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end

        SEND: begin
          if (abort) begin
            state      <= IDLE;
            idx        <= '0;
            data       <= IDLE_DATA;
            data_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (ready) begin
            if (idx != LAST_IDX) begin
              idx  <= idx + IDX_W'(1);
              data <= frame_sym(idx + IDX_W'(1));
            end else if (reps > REP_W'(1)) begin
              reps <= reps - REP_W'(1);
              idx  <= '0;
              if (gap_len == '0) begin
                data <= frame_sym('0);
              end else begin
                state      <= GAP;
                gap_cnt    <= gap_len;
                data       <= IDLE_DATA;
                data_valid <= 1'b0;
              end
            end else begin
              state      <= IDLE;
              idx        <= '0;
              data       <= IDLE_DATA;
              data_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
        end

        GAP: begin
          if (abort) begin
            state   <= IDLE;
            gap_cnt <= '0;
            busy    <= 1'b0;
          end else if (gap_cnt == GAP_W'(1)) begin
            state      <= SEND;
            gap_cnt    <= '0;
            data       <= frame_sym('0);
            data_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          state      <= IDLE;
          data       <= IDLE_DATA;
          data_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
